// File: rtl/ped_request_unit.sv
// Pedestrian request unit: synchronises/debounces the kerb button, holds the request, times the WALK phase.
// Optional press counter output enabled by defining PED_PRESS_COUNT_EN.
module ped_request_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 8,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button_raw,
    input  logic             walk,
    output logic             pedestrian_button,
    output logic             wait_lamp,
    output logic             walk_lamp,
    output logic [CNT_W-1:0] walk_countdown
`ifdef PED_PRESS_COUNT_EN
    ,
    output logic [7:0]       press_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WALKING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic [CNT_W-1:0] deb_cnt;
    logic             press_evt;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] countdown;
    logic [CNT_W-1:0] countdown_nxt;
    logic             pending;
    logic             pending_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= button_raw;
            sync2 <= sync1;
            if (sync2 != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Only the debounced rising edge is an event; releases are silent.
    assign press_evt = (deb_cnt == DEB_LAST) && sync2 && !deb;

    always_comb begin
        state_nxt     = state;
        countdown_nxt = countdown;
        pending_nxt   = pending;
        case (state)
            IDLE: begin
                if (press_evt) state_nxt = REQUEST;
            end
            REQUEST: begin
                if (walk) begin
                    state_nxt     = WALKING;
                    countdown_nxt = WALK_LOAD;
                end
            end
            WALKING: begin
                if (countdown == '0) begin
                    state_nxt   = (pending || press_evt) ? REQUEST : IDLE;
                    pending_nxt = 1'b0;
                end else begin
                    countdown_nxt = countdown - CNT_W'(1);
                    if (press_evt) pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                countdown_nxt = '0;
                pending_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            countdown         <= '0;
            pending           <= 1'b0;
            pedestrian_button <= 1'b0;
            wait_lamp         <= 1'b0;
            walk_lamp         <= 1'b0;
            walk_countdown    <= '0;
        end else begin
            state             <= state_nxt;
            countdown         <= countdown_nxt;
            pending           <= pending_nxt;
            pedestrian_button <= (state_nxt == REQUEST);
            wait_lamp         <= (state_nxt == REQUEST);
            walk_lamp         <= (state_nxt == WALKING);
            walk_countdown    <= (state_nxt == WALKING) ? countdown_nxt : '0;
        end
    end

`ifdef PED_PRESS_COUNT_EN
    logic accept;

    // A press counts only when it changes what the unit will do.
    assign accept = press_evt && ((state == IDLE) || ((state == WALKING) && !pending));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_count <= 8'd0;
        end else if (accept && (press_count != 8'hFF)) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ped_request_unit.sv
// Bench for ped_request_unit: directed scenarios plus random button/walk traffic against a behavioural model.
module tb_ped_request_unit;
    localparam int D  = 4;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          button_raw = 1'b0;
    logic          walk = 1'b0;
    logic          pedestrian_button;
    logic          wait_lamp;
    logic          walk_lamp;
    logic [CW-1:0] walk_countdown;
`ifdef PED_PRESS_COUNT_EN
    logic [7:0]    press_count;
`endif

    always #5 clk = ~clk;

    ped_request_unit #(.DEBOUNCE_CYCLES(D), .WALK_CYCLES(W), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .button_raw        (button_raw),
        .walk              (walk),
        .pedestrian_button (pedestrian_button),
        .wait_lamp         (wait_lamp),
        .walk_lamp         (walk_lamp),
        .walk_countdown    (walk_countdown)
`ifdef PED_PRESS_COUNT_EN
        ,
        .press_count       (press_count)
`endif
    );

    // Model: mode 0=idle 1=requesting 2=walking; m_left = lamp cycles still to show.
    int m_s1, m_s2, m_deb, m_run, m_mode, m_left, m_pend, m_cnt;
    int n_cmp = 0;
    int n_err = 0;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
        m_mode = 0; m_left = 0; m_pend = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit press;
        press = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        // The debounced level follows the synchronised input after D consecutive differing edges.
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == D) begin
                m_deb = m_s2;
                m_run = 0;
                press = (m_deb == 1);
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(button_raw);
        case (m_mode)
            0: if (press) begin m_mode = 1; m_cnt++; end
            1: if (walk) begin m_mode = 2; m_left = W; end
            default: begin
                if (m_left == 1) begin
                    if (press && !m_pend) m_cnt++;
                    m_mode = (m_pend || press) ? 1 : 0;
                    m_pend = 0;
                    m_left = 0;
                end else begin
                    m_left--;
                    if (press && !m_pend) begin m_pend = 1; m_cnt++; end
                end
            end
        endcase
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        cmp("pedestrian_button", pedestrian_button, m_mode == 1);
        cmp("wait_lamp", wait_lamp, m_mode == 1);
        cmp("walk_lamp", walk_lamp, m_mode == 2);
        cmp("walk_countdown", walk_countdown, (m_mode == 2) ? m_left - 1 : 0);
`ifdef PED_PRESS_COUNT_EN
        cmp("press_count", press_count, (m_cnt > 255) ? 255 : m_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int lamp_cycles;
        int hold;
        int cyc;
        bit reached;
        model_reset();

        // Reset held, then 20 quiet cycles.
        steps(3);
        cmp("reset_ped", pedestrian_button, 1'b0);
        cmp("reset_cd", walk_countdown, 0);
        rst = 1'b0;
        steps(20);

        // A 3-cycle glitch must never raise the request.
        button_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); cmp("glitch_ped", pedestrian_button, 1'b0); end
        button_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); cmp("glitch_ped", pedestrian_button, 1'b0); end

        // Held press: request rises on the (D+2)th edge.
        button_raw = 1'b1;
        for (int i = 1; i <= D + 2; i++) begin
            step();
            cmp("press_latency", pedestrian_button, i == D + 2);
        end
        cmp("press_wait_lamp", wait_lamp, 1'b1);
        steps(3);
        walk = 1'b1;
        step();
        walk = 1'b0;
        for (int i = 0; i < W; i++) begin
            cmp("walk_lamp_on", walk_lamp, 1'b1);
            cmp("walk_cd_seq", walk_countdown, W - 1 - i);
            cmp("walk_ped_low", pedestrian_button, 1'b0);
            step();
        end
        cmp("walk_exit_lamp", walk_lamp, 1'b0);
        cmp("walk_exit_idle", pedestrian_button, 1'b0);

        // Press completing its debounce inside WALKING returns straight to REQUEST.
        button_raw = 1'b0;
        steps(D + 3);
        button_raw = 1'b1;
        steps(D + 2);
        button_raw = 1'b0;
        steps(D + 3);
        button_raw = 1'b1;
        walk = 1'b1;
        step();
        walk = 1'b0;
        steps(W);
        cmp("pending_req", pedestrian_button, 1'b1);
        cmp("pending_lamp", walk_lamp, 1'b0);

        // Walk pulse during WALKING does not extend it; walk in IDLE does nothing.
        walk = 1'b1;
        step();
        walk = 1'b0;
        lamp_cycles = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (walk_lamp) lamp_cycles++;
            walk = (i == 3);
            step();
        end
        walk = 1'b0;
        cmp("walk_duration", lamp_cycles, W);
        walk = 1'b1;
        step();
        walk = 1'b0;
        cmp("idle_walk_ignored", walk_lamp, 1'b0);
        step();

        // Reset at countdown 3 with a pending request.
        button_raw = 1'b0;
        steps(D + 3);
        button_raw = 1'b1;
        steps(D + 2);
        button_raw = 1'b0;
        steps(D + 3);
        button_raw = 1'b1;
        step();
        walk = 1'b1;
        step();
        walk = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 12 && !reached; i++) begin
            step();
            if (walk_countdown == 3) reached = 1'b1;
        end
        cmp("reach_cd3", reached, 1'b1);
        #2;
        rst = 1'b1;
        button_raw = 1'b0;
        #1;
        model_reset();
        cmp("async_rst_lamp", walk_lamp, 1'b0);
        cmp("async_rst_cd", walk_countdown, 0);
        cmp("async_rst_ped", pedestrian_button, 1'b0);
        steps(2);
        rst = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin step(); cmp("no_reissue", pedestrian_button, 1'b0); end

        // Random traffic against the model.
        hold = 1;
        cyc = 0;
`ifdef PED_PRESS_COUNT_EN
        while ((m_cnt < 300 || cyc < 3000) && cyc < 60000) begin
`else
        while (cyc < 4000) begin
`endif
            hold--;
            if (hold == 0) begin
                button_raw = ~button_raw;
                hold = $urandom_range(1, 10);
            end
            walk = ($urandom_range(0, 3) == 0);
            step();
            cyc++;
        end
        walk = 1'b0;
`ifdef PED_PRESS_COUNT_EN
        cmp("press_count_sat", press_count, 8'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ped_request_unit.md
Name: ped_request_unit

Overview:
- Pedestrian-side end of the crossing interface.
- Synchronises and debounces the raw kerb push-button, then raises and holds the pedestrian_button request toward the traffic light controller.
- Consumes the controller's walk pulse and times the local WALK lamp and countdown display.
- Queues one further request if the button is pressed during a walk phase.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced level changes (legal range 2..2^CNT_W-1).
- WALK_CYCLES, 8: cycles the walk_lamp stays lit per walk grant (legal range 1..2^CNT_W).
- CNT_W, 4: width of the debounce counter and the countdown counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- button_raw  input  1  raw, asynchronous, bouncing push-button contact.
- walk  input  1  walk grant from the controller; may be a single-cycle pulse.
- pedestrian_button  output  1  request to the controller; held high in REQUEST.
- wait_lamp  output  1  "WAIT" indicator; high in REQUEST.
- walk_lamp  output  1  "WALK" indicator; high in WALKING.
- walk_countdown  output  CNT_W  remaining walk cycles minus one; 0 outside WALKING.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; sync flops, debounced level, debounce counter, countdown and pending all 0. All outputs 0 while rst is high and on the first edge after release.
- Synchroniser: two-flop chain on button_raw gives sync2.
- Debounce counter:
  - Increments on each edge where sync2 != deb.
  - Clears on any edge where sync2 == deb.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch still holds, deb takes sync2 and the counter clears.
- press_evt (combinational) = counter==DEBOUNCE_CYCLES-1 && sync2 && !deb.
  - Fires once per debounced rising edge only; release edges produce no event.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Latency: with button_raw high from before edge 1, the FSM enters REQUEST on edge 2+DEBOUNCE_CYCLES (edge 6 at defaults).
- FSM states (outputs decoded from the registered state, Moore):
  - IDLE (all lamps 0, pedestrian_button=0):
    - press_evt -> REQUEST.
    - walk is ignored.
  - REQUEST (pedestrian_button=1, wait_lamp=1):
    - walk=1 -> WALKING, countdown loads WALK_CYCLES-1.
    - press_evt is ignored (request already outstanding).
    - walk coincident with press_evt: walk wins and the press is discarded.
  - WALKING (walk_lamp=1, walk_countdown=countdown):
    - countdown decrements each edge.
    - When countdown==0, the next edge exits:
      - to REQUEST if pending=1 (pending clears on that same edge);
      - otherwise to IDLE.
    - walk_lamp is therefore high for exactly WALK_CYCLES cycles.
    - walk is ignored; it neither restarts nor extends the phase.
    - press_evt sets pending; pending holds at most one request (a second press is absorbed).
    - press_evt on the exit edge is still captured and results in REQUEST.
- pedestrian_button drops on the edge that enters WALKING. The controller sees the request for at least one full cycle.
- No illegal-state lockup: undefined state encodings return to IDLE on the next edge.
- rst asserted mid-walk or mid-debounce: immediate return to reset values, and any pending request is lost.

Optional Feature:
- Macro: PED_PRESS_COUNT_EN.
- Defined:
  - Adds output press_count [7:0], reset to 0.
  - Increments on every accepted press_evt (IDLE->REQUEST or pending set in WALKING) and saturates at 255.
  - Presses ignored in REQUEST and absorbed second presses do not count.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- rst high then released, no stimulus for 20 cycles -> all outputs 0, state IDLE throughout.
- button_raw pulses high for 3 cycles (DEBOUNCE_CYCLES=4) -> pedestrian_button never rises.
- button_raw held high from before edge 1 -> pedestrian_button and wait_lamp rise at edge 6. A 1-cycle walk pulse at edge 10 -> walk_lamp high edges 11-18, walk_countdown 7,6,...,0, then IDLE at edge 19.
- Second debounced press during WALKING -> at countdown exit, state returns to REQUEST with pedestrian_button=1 and no new debounce delay. A third press in the same phase is absorbed (single pending request).
- walk pulse while IDLE and while WALKING -> no state change, and WALKING duration is unchanged.
- rst asserted at countdown=3 with pending=1 -> all outputs 0 immediately, IDLE after release, no request reissued. With PED_PRESS_COUNT_EN: 300 accepted presses -> press_count=255.
